// File: rtl/float_point_adder_issuer_if.sv
// Handshake bundle between the issuer, its request source, the floating-point adder and the result sink.
// The slave view belongs to the issuer; the master view belongs to its environment.
interface float_point_adder_issuer_if #(
  parameter int OPERAND_EXPONENT_WIDTH_IN_BITS = 11,
  parameter int OPERAND_FRACTION_WIDTH_IN_BITS = 52
);
  localparam int E = OPERAND_EXPONENT_WIDTH_IN_BITS;
  localparam int F = OPERAND_FRACTION_WIDTH_IN_BITS;
  localparam int W = 1 + E + F;

  logic         request_valid_in;
  logic         request_ready_out;
  logic         request_operation_in;
  logic [W-1:0] request_operand_0_in;
  logic [W-1:0] request_operand_1_in;

  logic         operantion_mode_out;
  logic         operand_0_valid_out;
  logic         operand_1_valid_out;
  logic         operand_0_sign_out;
  logic         operand_1_sign_out;
  logic [E-1:0] operand_0_exponent_out;
  logic [E-1:0] operand_1_exponent_out;
  logic [F-1:0] operand_0_fraction_out;
  logic [F-1:0] operand_1_fraction_out;
  logic         issue_ack_in;

  logic         product_valid_in;
  logic         product_sign_in;
  logic [E-1:0] product_exponent_in;
  logic [F-1:0] product_fraction_in;
  logic         product_ack_out;

  logic         result_valid_out;
  logic         result_ready_in;
  logic [W-1:0] result_data_out;

  modport slave (
    input  request_valid_in, request_operation_in, request_operand_0_in, request_operand_1_in,
    output request_ready_out,
    output operantion_mode_out, operand_0_valid_out, operand_1_valid_out,
    output operand_0_sign_out, operand_1_sign_out,
    output operand_0_exponent_out, operand_1_exponent_out,
    output operand_0_fraction_out, operand_1_fraction_out,
    input  issue_ack_in,
    input  product_valid_in, product_sign_in, product_exponent_in, product_fraction_in,
    output product_ack_out,
    output result_valid_out, result_data_out,
    input  result_ready_in
  );

  modport master (
    output request_valid_in, request_operation_in, request_operand_0_in, request_operand_1_in,
    input  request_ready_out,
    input  operantion_mode_out, operand_0_valid_out, operand_1_valid_out,
    input  operand_0_sign_out, operand_1_sign_out,
    input  operand_0_exponent_out, operand_1_exponent_out,
    input  operand_0_fraction_out, operand_1_fraction_out,
    output issue_ack_in,
    output product_valid_in, product_sign_in, product_exponent_in, product_fraction_in,
    input  product_ack_out,
    input  result_valid_out, result_data_out,
    output result_ready_in
  );
endinterface

// File: rtl/float_point_adder_issuer.sv
// Queues add/subtract requests and feeds them one at a time to an external floating-point adder,
// then holds each adder result until the downstream sink takes it.
module float_point_adder_issuer #(
  parameter int OPERAND_EXPONENT_WIDTH_IN_BITS = 11,
  parameter int OPERAND_FRACTION_WIDTH_IN_BITS = 52,
  parameter int QUEUE_DEPTH                    = 4
) (
  input logic                       clk_in,
  input logic                       reset_in,
  float_point_adder_issuer_if.slave bus
);
  localparam int E     = OPERAND_EXPONENT_WIDTH_IN_BITS;
  localparam int F     = OPERAND_FRACTION_WIDTH_IN_BITS;
  localparam int W     = 1 + E + F;
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] ISSUE        = 2'd1;
  localparam logic [1:0] WAIT_PRODUCT = 2'd2;
  localparam logic [1:0] DELIVER      = 2'd3;

  logic [1:0]       state;
  logic [2*W:0]     queue_mem [QUEUE_DEPTH];  // {operation, operand_0, operand_1}
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             op_reg;
  logic [W-1:0]     operand_0;
  logic [W-1:0]     operand_1;
  logic [W-1:0]     result;
  logic             push;
  logic             pop;

  assign bus.request_ready_out = reset_in && (count != FULL_COUNT);
  assign push = bus.request_valid_in && bus.request_ready_out;
  assign pop  = (state == IDLE) && (count != '0);

  // NOTE: queue storage carries no reset; an entry is only read after a push has written it.
  always_ff @(posedge clk_in) begin
    if (push) begin
      queue_mem[wr_ptr] <= {bus.request_operation_in, bus.request_operand_0_in,
                            bus.request_operand_1_in};
    end
  end

  // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state     <= IDLE;
      op_reg    <= 1'b0;
      operand_0 <= '0;
      operand_1 <= '0;
      result    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            {op_reg, operand_0, operand_1} <= queue_mem[rd_ptr];
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.issue_ack_in) state <= WAIT_PRODUCT;
        end
        WAIT_PRODUCT: begin
          if (bus.product_valid_in) begin
            result <= {bus.product_sign_in, bus.product_exponent_in, bus.product_fraction_in};
            state  <= DELIVER;
          end
        end
        DELIVER: begin
          if (bus.result_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid and ack strobes are also gated by reset so they drop in the cycle reset is asserted.
  assign bus.operantion_mode_out    = op_reg;
  assign bus.operand_0_valid_out    = reset_in && (state == ISSUE);
  assign bus.operand_1_valid_out    = reset_in && (state == ISSUE);
  assign bus.operand_0_sign_out     = operand_0[W-1];
  assign bus.operand_1_sign_out     = operand_1[W-1];
  assign bus.operand_0_exponent_out = operand_0[W-2 -: E];
  assign bus.operand_1_exponent_out = operand_1[W-2 -: E];
  assign bus.operand_0_fraction_out = operand_0[F-1:0];
  assign bus.operand_1_fraction_out = operand_1[F-1:0];

  assign bus.product_ack_out  = reset_in && (state == WAIT_PRODUCT) && bus.product_valid_in;
  assign bus.result_valid_out = reset_in && (state == DELIVER);
  assign bus.result_data_out  = result;
endmodule

// File: doc/float_point_adder_issuer.md
FLOAT_POINT_ADDER_ISSUER -- requirements
Module: float_point_adder_issuer

Interface
REQ-001 SHALL have parameter OPERAND_EXPONENT_WIDTH_IN_BITS, default 11, exponent field width.
REQ-002 SHALL have parameter OPERAND_FRACTION_WIDTH_IN_BITS, default 52, fraction field width; W = 1 + exponent width + fraction width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, request queue entries, power of two, at least 2.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_in  input  1  synchronous reset, active-low.
REQ-006 request_valid_in, request_ready_out  in/out  1  request handshake.
REQ-007 request_operation_in  input  1  0 = add, 1 = subtract.
REQ-008 request_operand_0_in, request_operand_1_in  input  W  packed operands {sign, exponent, fraction}.
REQ-009 operantion_mode_out  output  1  operation for the adder.
REQ-010 operand_0/1_valid_out, operand_0/1_sign_out  output  1 each  operands to the adder.
REQ-011 operand_0/1_exponent_out, operand_0/1_fraction_out  output  E, F  operands to the adder.
REQ-012 issue_ack_in  input  1  adder has accepted the presented operands.
REQ-013 product_valid_in, product_sign_in  input  1  result from the adder.
REQ-014 product_exponent_in, product_fraction_in  input  E, F  result fields.
REQ-015 product_ack_out  output  1  acknowledges the adder result; drives the adder's issue_ack_in.
REQ-016 result_valid_out, result_ready_in  out/in  1  result handshake.
REQ-017 result_data_out  output  W  packed result {sign, exponent, fraction}.

Function
REQ-018 Queue: an entry holds {operation, operand_0, operand_1}; push when request_valid_in and request_ready_out are both 1; request_ready_out = queue not full.
REQ-019 Queue pointers SHALL wrap modulo QUEUE_DEPTH; count ranges 0..QUEUE_DEPTH; a push and a pop in the same cycle leave the count unchanged.
REQ-020 Request fields SHALL be held unchanged in the queue; no arithmetic is performed on them.
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT_PRODUCT, DELIVER, with at most one operation in flight.
REQ-022 IDLE: if the queue is not empty, pop the head into the operand registers on that edge and go to ISSUE.
REQ-023 IDLE: if the queue is empty, stay in IDLE.
REQ-024 Operand unpack: sign = bit W-1, exponent = the next E bits, fraction = the low F bits.
REQ-025 ISSUE: both operand valid outputs = 1; all operand outputs held stable until issue_ack_in is sampled 1, then go to WAIT_PRODUCT.
REQ-026 Operand valid outputs SHALL be 0 in every state other than ISSUE.
REQ-027 WAIT_PRODUCT: product_ack_out = product_valid_in (combinational) only in this state, and 0 in all other states.
REQ-028 WAIT_PRODUCT: on a product_valid_in edge, capture {sign, exponent, fraction} into the result register and go to DELIVER.
REQ-029 DELIVER: result_valid_out = 1 with result_data_out stable until result_ready_in = 1, then go to IDLE.
REQ-030 result_valid_out SHALL be 0 outside DELIVER.
REQ-031 Minimum latency, request accept to result_valid_out, is 4 cycles plus adder latency; back-to-back operations are separated by an IDLE cycle.
REQ-032 Products arriving outside WAIT_PRODUCT SHALL be ignored and not acknowledged.
REQ-033 Queue pushes SHALL continue in every FSM state.

Reset
REQ-034 While reset_in = 0: state IDLE, queue empty, request_ready_out = 0.
REQ-035 While reset_in = 0: all valid outputs and product_ack_out = 0; data outputs and registers = 0.
REQ-036 Reset in mid-operation SHALL discard queued and in-flight operations with no acknowledgement.
REQ-037 request_ready_out = 1 in the first cycle after reset_in returns to 1.

Verification
REQ-038 Single add: push op=0, a=0x3FF0000000000000, b=0x4000000000000000; ack after 1 cycle; product {0, 0x400, 0x8000000000000} -> product_ack_out pulses once, result_data_out = 0x4008000000000000.
REQ-039 Fill: hold issue_ack_in = 0 and push 5 requests -> after the first pop, 4 accepted, request_ready_out = 0.
REQ-040 Drain fill: release acks -> request_ready_out returns to 1 after one pop; results appear in request order.
REQ-041 Backpressure: result_ready_in = 0 for 10 cycles -> result_valid_out and data held; no further issue; product_ack_out = 0 for a spurious product_valid_in.
REQ-042 Wrap: 9 sequential requests with depth 4 -> all 9 results correct and in order; simultaneous push and pop keep the count constant.
REQ-043 Reset in WAIT_PRODUCT: reset_in = 0 for 1 cycle -> outputs zero, queue empty, a later product_valid_in gets no ack, next request is processed normally.
